atm_machine: RTL and testbench

- Single-account ATM controller FSM.
- Accepts a 4-bit card ID and a 4-digit keypad PIN, then services withdrawal, deposit and mini-statement requests against an 8-bit balance register.
- Locks after repeated wrong PINs.
- Standalone leaf block; all inputs are sampled on the clock and all outputs are registered.

---
 rtl/atm_machine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_atm_machine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_machine.sv
// atm_machine: single-account ATM controller.
// Card check, 4-digit PIN entry with lockout, then withdrawal / deposit /
// mini-statement service against an 8-bit saturating balance register.
// All outputs are registered; reset is synchronous and active-high.
// Optional build macro: ATM_SESSION_LIMIT_EN adds a per-session cap of
// 8'd20 on the total amount withdrawn between card insertion and exit.
module atm_machine #(
  parameter logic [3:0]  CARD_ID      = 4'hA,
  parameter logic [15:0] PIN          = 16'h0123,
  parameter logic [7:0]  INIT_BALANCE = 8'd100,
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad,
  input  logic [3:0] card_swipe,
  input  logic [3:0] withdrawal_amount,
  input  logic [3:0] deposit_amount,
  output logic [7:0] display,
  output logic       locked,
  output logic [7:0] mini_statement
);

  localparam int unsigned ATT_W = (MAX_ATTEMPTS < 2) ? 1 : $clog2(MAX_ATTEMPTS + 1);

  localparam logic [3:0] KEY_ENTER  = 4'h0;
  localparam logic [3:0] KEY_STMT   = 4'hD;
  localparam logic [3:0] KEY_EXIT   = 4'hF;
  localparam logic [7:0] DISP_BLANK = 8'h00;
  localparam logic [7:0] DISP_ERR   = 8'hEE;
  localparam logic [7:0] DISP_LOCK  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_MENU,
    S_HOLD,
    S_LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       balance_q,   balance_d;
  logic [ATT_W-1:0] attempts_q,  attempts_d;
  logic [1:0]       txn_cnt_q,   txn_cnt_d;
  logic [7:0]       mini_q,      mini_d;
  logic [7:0]       display_q,   display_d;
  logic             locked_q,    locked_d;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic [11:0]      pin_shift_q, pin_shift_d;
  logic [3:0]       snap_key_q,  snap_key_d;
  logic [3:0]       snap_wd_q,   snap_wd_d;
  logic [3:0]       snap_dep_q,  snap_dep_d;

  logic       card_ok_c;
  logic       pin_match_c;
  logic       last_try_c;
  logic       txn_req_c;
  logic       hold_exit_c;
  logic       wd_ok_c;
  logic       limit_ok_c;
  logic [1:0] txn_next_c;
  logic [7:0] wd_bal_c;
  logic [8:0] dep_sum_c;
  logic [7:0] dep_sat_c;

`ifdef ATM_SESSION_LIMIT_EN
  logic [7:0] total_q, total_d;

  // Withdrawal allowed only if the session total stays within 20
  assign limit_ok_c = ({1'b0, total_q} + 9'(withdrawal_amount)) <= 9'd20;
`else
  assign limit_ok_c = 1'b1;
`endif

  // Shared decode of the sampled inputs
  assign card_ok_c   = (card_swipe == CARD_ID);
  assign pin_match_c = ({pin_shift_q, keypad} == PIN);
  assign last_try_c  = (32'(attempts_q) + 32'd1) >= MAX_ATTEMPTS;
  assign txn_req_c   = (withdrawal_amount != 4'd0) || (deposit_amount != 4'd0);
  assign hold_exit_c = (keypad != snap_key_q) || (withdrawal_amount != snap_wd_q) ||
                       (deposit_amount != snap_dep_q);
  assign wd_ok_c     = ({4'd0, withdrawal_amount} <= balance_q) && limit_ok_c;
  assign txn_next_c  = txn_cnt_q + 2'd1;
  assign wd_bal_c    = balance_q - {4'd0, withdrawal_amount};
  assign dep_sum_c   = {1'b0, balance_q} + 9'(deposit_amount);
  assign dep_sat_c   = dep_sum_c[8] ? 8'hFF : dep_sum_c[7:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (card_ok_c && !locked_q) state_d = S_PIN;
      end
      S_PIN: begin
        if (!card_ok_c) begin
          state_d = S_IDLE;
        end else if (digit_cnt_q == 2'd3) begin
          if (pin_match_c)     state_d = S_MENU;
          else if (last_try_c) state_d = S_LOCKED;
        end
      end
      S_MENU: begin
        if (!card_ok_c) begin
          state_d = S_IDLE;
        end else begin
          case (keypad)
            KEY_ENTER: if (txn_req_c) state_d = S_HOLD;
            KEY_STMT:  state_d = S_HOLD;
            KEY_EXIT:  state_d = S_IDLE;
            default:   ;
          endcase
        end
      end
      S_HOLD: begin
        if (!card_ok_c)       state_d = S_IDLE;
        else if (hold_exit_c) state_d = S_MENU;
      end
      S_LOCKED: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    balance_d   = balance_q;
    attempts_d  = attempts_q;
    txn_cnt_d   = txn_cnt_q;
    mini_d      = mini_q;
    display_d   = display_q;
    locked_d    = locked_q;
    digit_cnt_d = digit_cnt_q;
    pin_shift_d = pin_shift_q;
    snap_key_d  = snap_key_q;
    snap_wd_d   = snap_wd_q;
    snap_dep_d  = snap_dep_q;
`ifdef ATM_SESSION_LIMIT_EN
    total_d     = total_q;
`endif
    case (state_q)
      S_IDLE: begin
        display_d   = DISP_BLANK;
        digit_cnt_d = 2'd0;
`ifdef ATM_SESSION_LIMIT_EN
        if (card_ok_c && !locked_q) total_d = 8'd0;
`endif
      end
      S_PIN: begin
        if (!card_ok_c) begin
          digit_cnt_d = 2'd0;
          display_d   = DISP_BLANK;
        end else if (digit_cnt_q == 2'd3) begin
          digit_cnt_d = 2'd0;
          if (pin_match_c) begin
            attempts_d = '0;
            display_d  = balance_q;
          end else begin
            attempts_d = attempts_q + ATT_W'(1);
            if (last_try_c) begin
              display_d = DISP_LOCK;
              locked_d  = 1'b1;
            end else begin
              display_d = DISP_ERR;
            end
          end
        end else begin
          pin_shift_d = {pin_shift_q[7:0], keypad};
          digit_cnt_d = digit_cnt_q + 2'd1;
          display_d   = {6'd0, digit_cnt_q + 2'd1};
        end
      end
      S_MENU: begin
        // Snapshot inputs every menu cycle; only the one that enters HOLD matters
        snap_key_d = keypad;
        snap_wd_d  = withdrawal_amount;
        snap_dep_d = deposit_amount;
        if (!card_ok_c) begin
          display_d = DISP_BLANK;
        end else begin
          case (keypad)
            KEY_ENTER: begin
              if (withdrawal_amount != 4'd0) begin
                txn_cnt_d = txn_next_c;
                if (wd_ok_c) begin
                  balance_d = wd_bal_c;
                  mini_d    = {2'b01, txn_next_c, withdrawal_amount};
                  display_d = wd_bal_c;
`ifdef ATM_SESSION_LIMIT_EN
                  total_d   = total_q + 8'(withdrawal_amount);
`endif
                end else begin
                  mini_d    = {2'b11, txn_next_c, withdrawal_amount};
                  display_d = DISP_ERR;
                end
              end else if (deposit_amount != 4'd0) begin
                txn_cnt_d = txn_next_c;
                balance_d = dep_sat_c;
                mini_d    = {2'b10, txn_next_c, deposit_amount};
                display_d = dep_sat_c;
              end else begin
                display_d = balance_q;
              end
            end
            KEY_STMT: display_d = mini_q;
            KEY_EXIT: display_d = DISP_BLANK;
            default:  display_d = balance_q;
          endcase
        end
      end
      S_HOLD: begin
        if (!card_ok_c)       display_d = DISP_BLANK;
        else if (hold_exit_c) display_d = balance_q;
      end
      S_LOCKED: begin
        display_d = DISP_LOCK;
        locked_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      balance_q   <= INIT_BALANCE;
      attempts_q  <= '0;
      txn_cnt_q   <= 2'd0;
      mini_q      <= 8'h00;
      display_q   <= DISP_BLANK;
      locked_q    <= 1'b0;
      digit_cnt_q <= 2'd0;
      pin_shift_q <= 12'd0;
      snap_key_q  <= 4'd0;
      snap_wd_q   <= 4'd0;
      snap_dep_q  <= 4'd0;
`ifdef ATM_SESSION_LIMIT_EN
      total_q     <= 8'd0;
`endif
    end else begin
      balance_q   <= balance_d;
      attempts_q  <= attempts_d;
      txn_cnt_q   <= txn_cnt_d;
      mini_q      <= mini_d;
      display_q   <= display_d;
      locked_q    <= locked_d;
      digit_cnt_q <= digit_cnt_d;
      pin_shift_q <= pin_shift_d;
      snap_key_q  <= snap_key_d;
      snap_wd_q   <= snap_wd_d;
      snap_dep_q  <= snap_dep_d;
`ifdef ATM_SESSION_LIMIT_EN
      total_q     <= total_d;
`endif
    end
  end

  assign display        = display_q;
  assign locked         = locked_q;
  assign mini_statement = mini_q;

endmodule

// File: tb/tb_atm_machine.sv
// tb_atm_machine: directed plus randomized bench for atm_machine with a
// session-level behavioural model compared against the DUT every cycle.
module tb_atm_machine;

  localparam logic [3:0]  CARD = 4'hA;
  localparam logic [15:0] PINV = 16'h0123;
  localparam int M_IDLE = 0, M_PIN = 1, M_MENU = 2, M_HOLD = 3, M_LOCKED = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keypad = 4'd0;
  logic [3:0] card_swipe = 4'd0;
  logic [3:0] withdrawal_amount = 4'd0;
  logic [3:0] deposit_amount = 4'd0;
  logic [7:0] display;
  logic       locked;
  logic [7:0] mini_statement;

  int checks = 0;
  int failures = 0;

  atm_machine dut (
    .clk               (clk),
    .reset             (reset),
    .keypad            (keypad),
    .card_swipe        (card_swipe),
    .withdrawal_amount (withdrawal_amount),
    .deposit_amount    (deposit_amount),
    .display           (display),
    .locked            (locked),
    .mini_statement    (mini_statement)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit         m_valid = 1'b0;
  int         m_mode, m_balance, m_attempts, m_txns, m_total;
  logic [7:0] m_display, m_mini;
  logic       m_locked;
  logic [3:0] m_digits[$];
  logic [3:0] s_kp, s_wd, s_dep;
  logic [15:0] entered;
  bit         card_in, lim_ok;

  // Model advances on the same edge the DUT samples its inputs
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_mode = M_IDLE; m_balance = 100; m_attempts = 0;
      m_txns = 0; m_total = 0; m_display = 8'h00; m_mini = 8'h00;
      m_locked = 1'b0; m_digits.delete();
    end else if (m_valid) begin
      card_in = (card_swipe == CARD);
      case (m_mode)
        M_IDLE: begin
          m_display = 8'h00;
          if (card_in && !m_locked) begin
            m_mode = M_PIN; m_digits.delete(); m_total = 0;
          end
        end
        M_PIN: begin
          if (!card_in) begin
            m_mode = M_IDLE; m_digits.delete(); m_display = 8'h00;
          end else begin
            m_digits.push_back(keypad);
            if (m_digits.size() < 4) begin
              m_display = 8'(m_digits.size());
            end else begin
              entered = {m_digits[0], m_digits[1], m_digits[2], m_digits[3]};
              m_digits.delete();
              if (entered == PINV) begin
                m_attempts = 0; m_mode = M_MENU; m_display = 8'(m_balance);
              end else begin
                m_attempts++;
                if (m_attempts >= 3) begin
                  m_mode = M_LOCKED; m_locked = 1'b1; m_display = 8'hFF;
                end else begin
                  m_display = 8'hEE;
                end
              end
            end
          end
        end
        M_MENU: begin
          if (!card_in) begin
            m_mode = M_IDLE; m_display = 8'h00;
          end else if (keypad == 4'h0) begin
            if (withdrawal_amount != 0) begin
              m_txns = (m_txns + 1) % 4;
`ifdef ATM_SESSION_LIMIT_EN
              lim_ok = (m_total + int'(withdrawal_amount)) <= 20;
`else
              lim_ok = 1'b1;
`endif
              if (int'(withdrawal_amount) <= m_balance && lim_ok) begin
                m_balance -= int'(withdrawal_amount);
                m_total += int'(withdrawal_amount);
                m_mini = {2'b01, 2'(m_txns), withdrawal_amount};
                m_display = 8'(m_balance);
              end else begin
                m_mini = {2'b11, 2'(m_txns), withdrawal_amount};
                m_display = 8'hEE;
              end
              m_mode = M_HOLD;
            end else if (deposit_amount != 0) begin
              m_txns = (m_txns + 1) % 4;
              m_balance += int'(deposit_amount);
              if (m_balance > 255) m_balance = 255;
              m_mini = {2'b10, 2'(m_txns), deposit_amount};
              m_display = 8'(m_balance);
              m_mode = M_HOLD;
            end else begin
              m_display = 8'(m_balance);
            end
            s_kp = keypad; s_wd = withdrawal_amount; s_dep = deposit_amount;
          end else if (keypad == 4'hD) begin
            m_display = m_mini; m_mode = M_HOLD;
            s_kp = keypad; s_wd = withdrawal_amount; s_dep = deposit_amount;
          end else if (keypad == 4'hF) begin
            m_mode = M_IDLE; m_display = 8'h00;
          end else begin
            m_display = 8'(m_balance);
          end
        end
        M_HOLD: begin
          if (!card_in) begin
            m_mode = M_IDLE; m_display = 8'h00;
          end else if (keypad != s_kp || withdrawal_amount != s_wd || deposit_amount != s_dep) begin
            m_mode = M_MENU; m_display = 8'(m_balance);
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check8("display", display, m_display);
      check8("locked", {7'd0, locked}, {7'd0, m_locked});
      check8("mini_statement", mini_statement, m_mini);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] c, input logic [3:0] k,
                       input logic [3:0] w, input logic [3:0] d);
    card_swipe = c; keypad = k; withdrawal_amount = w; deposit_amount = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
  endtask

  task automatic login();
    drive(CARD, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h1, 4'h0, 4'h0);
    drive(CARD, 4'h2, 4'h0, 4'h0);
    drive(CARD, 4'h3, 4'h0, 4'h0);
  endtask

  task automatic wrong_pin();
    for (int i = 0; i < 4; i++) drive(CARD, 4'h0, 4'h0, 4'h0);
  endtask

  function automatic logic [3:0] pin_digit(input int i);
    logic [15:0] p;
    p = PINV;
    return p[15-4*i -: 4];
  endfunction

  initial begin
    int n, r;
    logic [3:0] c, k, w;
    @(negedge clk);

    // Reset state
    do_reset();
    check8("rst_display", display, 8'h00);
    check8("rst_locked", {7'd0, locked}, 8'h00);
    check8("rst_mini", mini_statement, 8'h00);

    // Login, digit-count display, card removal
    drive(CARD, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h1, 4'h0, 4'h0);
    check8("pin_count2", display, 8'd2);
    drive(CARD, 4'h2, 4'h0, 4'h0);
    drive(CARD, 4'h3, 4'h0, 4'h0);
    check8("login_balance", display, 8'd100);
    check8("model_login_balance", m_display, 8'd100);
    check8("login_unlocked", {7'd0, locked}, 8'h00);
    drive(4'h0, 4'h3, 4'h0, 4'h0);
    check8("card_out_idle", display, 8'h00);

    // Held ENTER debits once
    login();
    repeat (3) drive(CARD, 4'h0, 4'h4, 4'h0);
    check8("wd4_balance", display, 8'd96);
    check8("wd4_mini", mini_statement, 8'h54);
    check8("model_wd4_mini", m_mini, 8'h54);
    drive(CARD, 4'h0, 4'h2, 4'h0);
    drive(CARD, 4'h0, 4'h2, 4'h0);
    check8("wd2_balance", display, 8'd94);
    check8("wd2_mini", mini_statement, 8'h62);
    drive(CARD, 4'h5, 4'h0, 4'h0);
    drive(4'h0, 4'h5, 4'h0, 4'h0);

    // Deposits, then drain to 10 and try an oversized withdrawal
    login();
    drive(CARD, 4'h0, 4'h0, 4'h4);
    check8("dep4_balance", display, 8'd98);
    check8("dep4_mini", mini_statement, 8'hB4);
    drive(CARD, 4'h0, 4'h0, 4'h2);
    drive(CARD, 4'h0, 4'h0, 4'h2);
    check8("dep2_balance", display, 8'd100);
    check8("dep2_mini", mini_statement, 8'h82);
    drive(CARD, 4'h5, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      drive(CARD, 4'h0, 4'hF, 4'h0);
      drive(CARD, 4'h5, 4'h0, 4'h0);
    end
    check8("drained_balance", display, 8'd10);
    drive(CARD, 4'h0, 4'hF, 4'h0);
    check8("reject_display", display, 8'hEE);
    check8("reject_mini", mini_statement, 8'hFF);
    drive(CARD, 4'h5, 4'h0, 4'h0);
    check8("reject_balance_kept", display, 8'd10);

    // Mini statement display held while keypad stays on D
    drive(CARD, 4'h0, 4'h0, 4'h3);
    drive(CARD, 4'h5, 4'h0, 4'h0);
    drive(CARD, 4'hD, 4'h0, 4'h0);
    check8("stmt_display", display, 8'h83);
    drive(CARD, 4'hD, 4'h0, 4'h0);
    check8("stmt_display_held", display, 8'h83);
    drive(CARD, 4'h5, 4'h0, 4'h0);
    check8("stmt_exit_balance", display, 8'd13);
    drive(4'h0, 4'h5, 4'h0, 4'h0);

    // Lockout after three wrong PINs
    drive(CARD, 4'h0, 4'h0, 4'h0);
    wrong_pin();
    check8("wrong1_display", display, 8'hEE);
    wrong_pin();
    wrong_pin();
    check8("lock_flag", {7'd0, locked}, 8'h01);
    check8("lock_display", display, 8'hFF);
    login();
    check8("lock_ignores_pin", display, 8'hFF);
    check8("lock_still_set", {7'd0, locked}, 8'h01);
    do_reset();
    check8("reset_unlocks", {7'd0, locked}, 8'h00);

    // Card pulled mid-PIN, then good login clears attempts
    drive(CARD, 4'h0, 4'h0, 4'h0);
    wrong_pin();
    drive(CARD, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h1, 4'h0, 4'h0);
    drive(4'h0, 4'h2, 4'h0, 4'h0);
    check8("midpin_idle", display, 8'h00);
    login();
    check8("relogin_balance", display, 8'd100);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    drive(CARD, 4'h0, 4'h0, 4'h0);
    wrong_pin();
    wrong_pin();
    check8("attempts_cleared", {7'd0, locked}, 8'h00);
    drive(4'h0, 4'h0, 4'h0, 4'h0);

    // Randomized sessions
    for (int s = 0; s < 150; s++) begin
      if ((m_locked && $urandom_range(0, 1) == 0) || $urandom_range(0, 99) < 3) do_reset();
      c = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : CARD;
      drive(c, 4'($urandom_range(0, 15)), 4'h0, 4'h0);
      for (int i = 0; i < 4; i++)
        drive(CARD, ($urandom_range(0, 9) < 8) ? pin_digit(i) : 4'($urandom_range(0, 15)), 4'h0, 4'h0);
      n = $urandom_range(5, 25);
      for (int j = 0; j < n; j++) begin
        c = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 15)) : CARD;
        r = $urandom_range(0, 99);
        if (r < 40)      k = 4'h0;
        else if (r < 55) k = 4'hD;
        else if (r < 60) k = 4'hF;
        else             k = 4'($urandom_range(0, 15));
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        drive(c, k, w, 4'($urandom_range(0, 15)));
      end
      drive(4'h0, 4'h0, 4'h0, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
